// File: rtl/latch_array_ctrl.sv
// latch_array_ctrl: valid/ready front end, init sweep and gated-clock drive for a 16-entry latch array
module latch_array_ctrl_cg (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic gclk
);
  logic en_l;
  // enable is captured while clk is high so the low-phase pulse can never glitch
  always_latch
    if (rst) en_l <= 1'b0;
    else if (clk) en_l <= en;
  assign gclk = en_l & ~clk;
endmodule

module latch_array_ctrl #(
  parameter int W = 8,
  parameter logic [W-1:0] INIT_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [3:0]   wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic         rd_valid,
  output logic         rd_ready,
  input  logic [3:0]   rd_addr,
  output logic [W-1:0] rd_data,
  output logic         rd_data_valid,
  output logic         init_done,
  output logic [W-1:0] DIN,
  output logic [15:0]  DGWCLK,
  output logic [15:0]  RWL,
  input  logic [W-1:0] DOUT
);
  typedef enum logic [1:0] {INIT, DRAIN, RUN} state_t;
  state_t state;
  logic [3:0] c, wa1, wa;
  logic [W-1:0] wd;
  logic [15:0] we2;
  logic v1, rdy, iss;
  assign wr_ready = rdy;
  assign rd_ready = rdy;
  assign init_done = rdy;
  assign iss = (state == INIT) | (wr_valid & rdy);
  assign wa = state == INIT ? c : wr_addr;
  assign wd = state == INIT ? INIT_VAL : wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= INIT;
      c <= '0;
      rdy <= 1'b0;
      v1 <= 1'b0;
      wa1 <= '0;
      DIN <= '0;
      we2 <= '0;
      RWL <= '0;
      rd_data <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      if (state == INIT) begin
        c <= c + 4'd1;
        if (c == 4'd15) state <= DRAIN;
      end else if (state == DRAIN) begin
        c <= c + 4'd1;
        if (c == 4'd1) begin
          state <= RUN;
          rdy <= 1'b1;
          c <= '0;
        end
      end
      v1 <= iss;
      if (iss) begin
        DIN <= wd;
        wa1 <= wa;
      end
      we2 <= v1 ? 16'd1 << wa1 : '0;
      RWL <= (rd_valid & rdy) ? 16'd1 << rd_addr : '0;
      rd_data_valid <= |RWL;
      if (|RWL) rd_data <= DOUT;
    end
  for (genvar i = 0; i < 16; i++) begin : g_cg
    latch_array_ctrl_cg u_cg (.clk(clk), .rst(rst), .en(we2[i]), .gclk(DGWCLK[i]));
  end
endmodule

// File: tb/tb_latch_array_ctrl.sv
// tb_latch_array_ctrl: latch-array model around the controller, transaction-level reference and vector table
module tb_latch_array_ctrl;
  localparam int W = 8;
  localparam logic [W-1:0] IV = 8'h00;
  typedef struct {
    bit wv; logic [3:0] wa; logic [W-1:0] wd;
    bit rv; logic [3:0] ra;
    bit ev; logic [W-1:0] ed;
  } vec_t;
  logic clk = 0, rst = 1, wr_valid = 0, rd_valid = 0;
  logic [3:0] wr_addr = 0, rd_addr = 0;
  logic [W-1:0] wr_data = 0, rd_data, DIN, DOUT, gdin;
  logic wr_ready, rd_ready, rd_data_valid, init_done;
  logic [15:0] DGWCLK, RWL;
  logic [W-1:0] mem [16];
  logic [W-1:0] ref_mem [16];
  logic [15:0] exp_gw [4];
  logic [15:0] exp_rwl [4];
  bit exp_rv [4];
  logic [W-1:0] exp_rd [4];
  logic [W-1:0] din_m = '0;
  int errors = 0, checks = 0, s = 0, cyc = 0;
  bit watch9 = 0, hit9 = 0;
  vec_t tv [11];

  always #5 clk = ~clk;

  latch_array_ctrl #(.W(W), .INIT_VAL(IV)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .init_done(init_done),
    .DIN(DIN), .DGWCLK(DGWCLK), .RWL(RWL), .DOUT(DOUT)
  );

  // array side: GDIN flop, latches written while their gated clock is high, read mux
  always @(posedge clk) gdin <= DIN;
  always @(negedge clk) begin
    #1;
    for (int i = 0; i < 16; i++) if (DGWCLK[i]) mem[i] = gdin;
  end
  always_comb begin
    DOUT = '0;
    for (int i = 0; i < 16; i++) if (RWL[i]) DOUT = DOUT | mem[i];
  end
  always @(posedge DGWCLK[9]) if (watch9) hit9 = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (slot %0d)", name, act, exp, s);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
    s++;
  endtask

  task automatic check_slot;
    int k;
    tick;
    k = s % 4;
    chk("dgwclk", 32'(DGWCLK), 32'(exp_gw[k]));
    chk("rwl", 32'(RWL), 32'(exp_rwl[k]));
    chk("rd_data_valid", 32'(rd_data_valid), 32'(exp_rv[k]));
    if (exp_rv[k]) chk("rd_data", 32'(rd_data), 32'(exp_rd[k]));
    chk("din", 32'(DIN), 32'(din_m));
    exp_gw[k] = '0;
    exp_rwl[k] = '0;
    exp_rv[k] = 0;
  endtask

  task automatic drive_slot(input bit wv, input logic [3:0] wa, input logic [W-1:0] wd,
                            input bit rv, input logic [3:0] ra);
    int n;
    bit run;
    n = (s + 2) % 4;
    run = cyc >= 18;
    chk("ready", 32'({wr_ready, rd_ready, init_done}), run ? 32'd7 : 32'd0);
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr = ra;
    if (cyc < 16) begin
      exp_gw[n] = 16'd1 << cyc;
      din_m = IV;
    end
    // a read sees every write accepted strictly before it
    if (rv && run) begin
      exp_rv[n] = 1;
      exp_rd[n] = ref_mem[ra];
      exp_rwl[(s + 1) % 4] = 16'd1 << ra;
    end
    if (wv && run) begin
      exp_gw[n] = 16'd1 << wa;
      ref_mem[wa] = wd;
      din_m = wd;
    end
    cyc++;
  endtask

  task automatic step(input bit wv, input logic [3:0] wa, input logic [W-1:0] wd,
                      input bit rv, input logic [3:0] ra);
    check_slot;
    drive_slot(wv, wa, wd, rv, ra);
  endtask

  task automatic do_reset;
    rst = 1;
    wr_valid = 0;
    rd_valid = 0;
    for (int i = 0; i < 4; i++) begin
      exp_gw[i] = '0; exp_rwl[i] = '0; exp_rv[i] = 0; exp_rd[i] = '0;
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = IV;
    din_m = '0;
    tick;
    chk("rst_din", 32'(DIN), 0);
    chk("rst_dgwclk", 32'(DGWCLK), 0);
    chk("rst_rwl", 32'(RWL), 0);
    chk("rst_rd", 32'({rd_data, rd_data_valid}), 0);
    chk("rst_ready", 32'({wr_ready, rd_ready, init_done}), 0);
    rst = 0;
    cyc = 0;
    drive_slot(1, 4'($urandom), 8'($urandom), 1, 4'($urandom));
    repeat (17) step(1, 4'($urandom), 8'($urandom), 1, 4'($urandom));
  endtask

  initial begin
    tv[0]  = '{1, 3, 8'hA5, 0, 0, 0, 8'h00};
    tv[1]  = '{0, 0, 8'h00, 1, 3, 0, 8'h00};
    tv[2]  = '{1, 7, 8'h11, 0, 0, 0, 8'h00};
    tv[3]  = '{0, 0, 8'h00, 0, 0, 1, 8'hA5};
    tv[4]  = '{1, 7, 8'h22, 1, 7, 0, 8'h00};
    tv[5]  = '{0, 0, 8'h00, 1, 7, 0, 8'h00};
    tv[6]  = '{0, 0, 8'h00, 0, 0, 1, 8'h11};
    tv[7]  = '{0, 0, 8'h00, 0, 0, 1, 8'h22};
    tv[8]  = '{0, 0, 8'h00, 1, 5, 0, 8'h00};
    tv[9]  = '{0, 0, 8'h00, 0, 0, 0, 8'h00};
    tv[10] = '{0, 0, 8'h00, 0, 0, 1, IV};
    do_reset;
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 4'(i));
    repeat (2) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      check_slot;
      chk("tv_valid", 32'(rd_data_valid), 32'(tv[i].ev));
      if (tv[i].ev) chk("tv_data", 32'(rd_data), 32'(tv[i].ed));
      drive_slot(tv[i].wv, tv[i].wa, tv[i].wd, tv[i].rv, tv[i].ra);
    end
    for (int i = 0; i < 16; i++) step(1, 4'(i), 8'(8'h10 + i), 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 4'(i));
    repeat (2) step(0, 0, 0, 0, 0);
    repeat (300) step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 8'($urandom),
                      1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)));
    repeat (22) step(0, 0, 0, 0, 0);
    step(1, 9, 8'hFF, 0, 0);
    step(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    watch9 = 1;
    rst = 1;
    @(posedge clk);
    #1;
    watch9 = 0;
    chk("no_dgwclk9_after_rst", 32'(hit9), 0);
    do_reset;
    step(0, 0, 0, 1, 9);
    repeat (2) step(0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
